fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, issues imem reads, and buffers one
// fetched word (with its PC+2) for the IF/ID register; absorbs stalls and redirects.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        load_if_id,
  output logic [15:0] pc_IF_out,
  output logic [15:0] ir_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, FETCH, SQUASH} state_t;

  localparam logic [15:0] RESET_PC_EVEN = RESET_PC & 16'hFFFE;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] pending_pc, pending_next;
  logic [15:0] ir_next, pc_if_next;
  logic        valid_next;
  logic [15:0] redirect_target;
  logic [15:0] pc_plus2;
  logic        buffer_free;

  assign redirect_target = redirect_pc & 16'hFFFE;
  assign pc_plus2        = 16'(pc + 16'd2);
  assign imem_address    = pc;
  assign imem_read       = ((state == FETCH) || (state == SQUASH)) && !reset;
  assign load_if_id      = valid_out & ~stall_in & ~redirect;
  assign buffer_free     = ~valid_out | load_if_id;

  // Next-state, PC and buffer update; a squash keeps the old request alive until it retires.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_pc;
    valid_next   = valid_out & ~load_if_id;
    ir_next      = ir_out;
    pc_if_next   = pc_IF_out;
    case (state)
      IDLE: begin
        if (redirect) begin
          pc_next    = redirect_target;
          valid_next = 1'b0;
        end else if (buffer_free) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (imem_resp) begin
          state_next = IDLE;
          if (redirect) begin
            pc_next    = redirect_target;
            valid_next = 1'b0;
          end else begin
            ir_next    = imem_rdata;
            pc_if_next = pc_plus2;
            valid_next = 1'b1;
            pc_next    = pc_plus2;
          end
        end else if (redirect) begin
          pending_next = redirect_target;
          valid_next   = 1'b0;
          state_next   = SQUASH;
        end
      end
      SQUASH: begin
        if (redirect) begin
          pending_next = redirect_target;
          valid_next   = 1'b0;
        end
        if (imem_resp) begin
          pc_next    = redirect ? redirect_target : pending_pc;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC_EVEN;
      pending_pc <= 16'h0000;
      valid_out  <= 1'b0;
      ir_out     <= 16'h0000;
      pc_IF_out  <= 16'h0000;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pending_pc <= pending_next;
      valid_out  <= valid_next;
      ir_out     <= ir_next;
      pc_IF_out  <= pc_if_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/latency traffic,
// checked against an instruction-stream model (delivered words must follow the program order).
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        load_if_id;
  logic [15:0] pc_IF_out;
  logic [15:0] ir_out;
  logic        valid_out;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .stall_in(stall_in), .redirect(redirect), .redirect_pc(redirect_pc),
    .load_if_id(load_if_id), .pc_IF_out(pc_IF_out), .ir_out(ir_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fixed_lat;
  int mem_cnt, mem_lat;
  bit mem_busy;
  int delivered;
  logic [15:0] exp_pc;
  logic        prev_read, prev_resp, prev_valid, prev_stall, prev_redirect;
  logic [15:0] prev_addr, prev_ir, prev_pcif;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h3000) return 16'h1234;
    return 16'(a * 16'd7) ^ 16'h5AC3;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs and memory at negedge, then check against the stream model.
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    stall_in    = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_resp   = 1'b0;
    imem_rdata  = 16'($urandom);
    if (imem_read) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (mem_cnt == mem_lat) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(imem_address);
        mem_busy   = 1'b0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_busy = 1'b0;
    end
    #1;
    check("load_eq", 16'(load_if_id), 16'(valid_out & ~stall_in & ~redirect));
    if (valid_out && stall_in) check("stall_rd", 16'(imem_read), 16'd0);
    if (!reset && prev_read && !prev_resp) begin
      check("hold_rd", 16'(imem_read), 16'd1);
      check("hold_addr", imem_address, prev_addr);
    end
    if (!reset && prev_valid && prev_stall && !prev_redirect) begin
      check("frozen_v", 16'(valid_out), 16'd1);
      check("frozen_ir", ir_out, prev_ir);
      check("frozen_pc", pc_IF_out, prev_pcif);
    end
    if (reset) begin
      exp_pc = RST_PC;
    end else begin
      if (load_if_id) begin
        check("deliv_ir", ir_out, mem_word(exp_pc));
        check("deliv_pc", pc_IF_out, 16'(exp_pc + 16'd2));
        exp_pc = 16'(exp_pc + 16'd2);
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc & 16'hFFFE;
    end
    prev_read     = imem_read;
    prev_resp     = imem_resp;
    prev_addr     = imem_address;
    prev_valid    = valid_out;
    prev_stall    = stall_in;
    prev_redirect = redirect;
    prev_ir       = ir_out;
    prev_pcif     = pc_IF_out;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_resp = 1'b0; imem_rdata = 16'h0;
    fixed_lat = 0; mem_busy = 1'b0; mem_cnt = 0; mem_lat = 0; delivered = 0;
    exp_pc = RST_PC;
    prev_read = 1'b0; prev_resp = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0;
    prev_redirect = 1'b0; prev_addr = 16'h0; prev_ir = 16'h0; prev_pcif = 16'h0;

    // reset state and first fetch
    repeat (2) step(1'b0, 1'b0, 16'h0);
    check("rst_rd", 16'(imem_read), 16'd0);
    check("rst_valid", 16'(valid_out), 16'd0);
    check("rst_ir", ir_out, 16'h0000);
    check("rst_pcif", pc_IF_out, 16'h0000);
    check("rst_load", 16'(load_if_id), 16'd0);
    check("rst_addr", imem_address, 16'h3000);
    reset = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    check("t1_rd", 16'(imem_read), 16'd1);
    check("t1_addr", imem_address, 16'h3000);
    step(1'b0, 1'b0, 16'h0);
    check("t1_valid", 16'(valid_out), 16'd1);
    check("t1_ir", ir_out, 16'h1234);
    check("t1_pcif", pc_IF_out, 16'h3002);
    check("t1_load", 16'(load_if_id), 16'd1);
    step(1'b0, 1'b0, 16'h0);
    check("t1_next", imem_address, 16'h3002);

    // five-cycle stall
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 16'h0);
      check("s_ir", ir_out, mem_word(16'h3002));
      check("s_pcif", pc_IF_out, 16'h3004);
      check("s_rd", 16'(imem_read), 16'd0);
      check("s_load", 16'(load_if_id), 16'd0);
    end
    step(1'b0, 1'b0, 16'h0);
    check("s_rel_load", 16'(load_if_id), 16'd1);
    fixed_lat = 3;
    step(1'b0, 1'b0, 16'h0);
    check("s_next_addr", imem_address, 16'h3004);
    check("s_next_valid", 16'(valid_out), 16'd0);

    // redirect during a 4-cycle wait
    step(1'b0, 1'b1, 16'h4000);
    check("r_addr", imem_address, 16'h3004);
    step(1'b0, 1'b0, 16'h0);
    check("r_addr2", imem_address, 16'h3004);
    check("r_valid", 16'(valid_out), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    check("r_addr3", imem_address, 16'h3004);
    check("r_resp", 16'(imem_resp), 16'd1);
    step(1'b0, 1'b0, 16'h0);
    check("r_valid_after", 16'(valid_out), 16'd0);
    check("r_rd_idle", 16'(imem_read), 16'd0);
    fixed_lat = 4;
    step(1'b0, 1'b0, 16'h0);
    check("r_new", imem_address, 16'h4000);

    // several redirects inside one squash; latest wins
    step(1'b0, 1'b1, 16'h6000);
    step(1'b0, 1'b1, 16'h4000);
    step(1'b0, 1'b1, 16'h5000);
    check("q_hold", imem_address, 16'h4000);
    step(1'b0, 1'b0, 16'h0);
    check("q_resp", 16'(imem_resp), 16'd1);
    fixed_lat = 0;
    step(1'b0, 1'b0, 16'h0);
    check("q_valid", 16'(valid_out), 16'd0);

    // redirect coincident with response in FETCH
    step(1'b0, 1'b1, 16'h7000);
    check("c_addr", imem_address, 16'h5000);
    check("c_resp", 16'(imem_resp), 16'd1);
    step(1'b0, 1'b0, 16'h0);
    check("c_valid", 16'(valid_out), 16'd0);
    check("c_rd", 16'(imem_read), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    check("c_new", imem_address, 16'h7000);

    // odd redirect target and PC wrap
    step(1'b0, 1'b1, 16'h4001);
    check("w_load", 16'(load_if_id), 16'd0);
    check("w_valid", 16'(valid_out), 16'd1);
    step(1'b0, 1'b0, 16'h0);
    check("w_rd", 16'(imem_read), 16'd0);
    check("w_valid0", 16'(valid_out), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    check("w_addr", imem_address, 16'h4000);
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    check("w_ffe", imem_address, 16'hFFFE);
    step(1'b0, 1'b0, 16'h0);
    check("w_pcif", pc_IF_out, 16'h0000);
    check("w_ir", ir_out, mem_word(16'hFFFE));
    check("w_load1", 16'(load_if_id), 16'd1);
    fixed_lat = 3;
    step(1'b0, 1'b0, 16'h0);
    check("w_zero", imem_address, 16'h0000);
    check("w_zero_rd", 16'(imem_read), 16'd1);

    // reset in the middle of an outstanding request
    reset = 1'b1;
    #1;
    check("m_rd", 16'(imem_read), 16'd0);
    check("m_valid", 16'(valid_out), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    reset = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    check("m_restart", imem_address, 16'h3000);
    check("m_restart_rd", 16'(imem_read), 16'd1);

    // random traffic
    fixed_lat = -1;
    for (int n = 0; n < 3000; n++) begin
      logic        st, rd;
      logic [15:0] rpc;
      st = ($urandom % 10) < 3;
      rd = ($urandom % 100) < 7;
      case ($urandom % 4)
        0: rpc = 16'($urandom);
        1: rpc = 16'hFFFC | 16'($urandom % 4);
        2: rpc = RST_PC;
        default: rpc = 16'($urandom) | 16'h0001;
      endcase
      step(st, rd, rpc);
    end
    check("progress", 16'(delivered > 200), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
